// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder and the processor controller:
// program geometry, instruction field positions and feeder state encoding.
package instr_feeder_pkg;
   localparam int IW    = 20;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   localparam int OPC_MSB = 19;
   localparam int OPC_LSB = 16;
   localparam int OPB_MSB = 15;
   localparam int OPB_LSB = 8;
   localparam int OPA_MSB = 7;
   localparam int OPA_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/instr_feeder_prog_ram.sv
// Program store: synchronous write, asynchronous read. The feeder FSM registers
// the read word, so contents are never reset and survive a feeder reset.
module instr_feeder_prog_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int IW    = 20
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [IW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [IW-1:0] rd_data
);
   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/instr_feeder.sv
// Program store and instruction issuer: host loads words, start issues them one
// at a time; a change on the controller address acknowledges the current word.
module instr_feeder #(
   parameter int DEPTH = instr_feeder_pkg::DEPTH,
   parameter int AW    = instr_feeder_pkg::AW,
   parameter int IW    = instr_feeder_pkg::IW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_data,
   input  logic          clear,
   input  logic          start,
   input  logic [AW-1:0] address,
   output logic [3:0]    opcode,
   output logic [7:0]    operand_b,
   output logic [7:0]    operand_a,
   output logic          op,
   output logic          busy,
   output logic          done,
   output logic          full,
   output logic [AW:0]   prog_len,
   output logic          seq_err
);
   import instr_feeder_pkg::*;

   state_t        state;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   issue_cnt;
   logic [AW-1:0] issue_addr;
   logic [IW-1:0] instr_reg;
   logic [IW-1:0] rd_data;
   logic          accept_wr;
   logic [AW:0]   next_len;

   // Writes land only while idle; clear beats a same-cycle write.
   assign full      = (wr_ptr == (AW+1)'(DEPTH));
   assign accept_wr = (state == IDLE) && wr_en && !full && !clear;
   assign next_len  = wr_ptr + {{AW{1'b0}}, accept_wr};

   instr_feeder_prog_ram #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_ram (
      .clk     (clk),
      .wr_en   (accept_wr),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (issue_cnt[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         issue_cnt  <= '0;
         issue_addr <= '0;
         instr_reg  <= '0;
         seq_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  wr_ptr <= '0;
                  if (start) state <= DONE;
               end else begin
                  if (accept_wr) wr_ptr <= next_len;
                  if (start) begin
                     if (next_len == '0) begin
                        state <= DONE;
                     end else begin
                        issue_cnt <= '0;
                        seq_err   <= 1'b0;
                        state     <= FETCH;
                     end
                  end
               end
            end
            FETCH: begin
               instr_reg  <= rd_data;
               issue_addr <= address;
               if (address != issue_cnt[AW-1:0]) seq_err <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: begin
               if (address != issue_addr) begin
                  issue_cnt <= issue_cnt + 1'b1;
                  state     <= ((issue_cnt + 1'b1) == wr_ptr) ? DONE : FETCH;
               end
            end
            DONE: begin
               if (clear) begin
                  wr_ptr <= '0;
                  state  <= IDLE;
               end else if (start && (wr_ptr != '0)) begin
                  issue_cnt <= '0;
                  seq_err   <= 1'b0;
                  state     <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign op        = (state == ISSUE);
   assign busy      = (state == FETCH) || (state == ISSUE);
   assign done      = (state == DONE);
   assign prog_len  = wr_ptr;
   assign opcode    = instr_reg[OPC_MSB:OPC_LSB];
   assign operand_b = instr_reg[OPB_MSB:OPB_LSB];
   assign operand_a = instr_reg[OPA_MSB:OPA_LSB];
endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: host loads programs, a controller model acknowledges
// each issued word by moving the address; results compared to a queue model.
module tb_instr_feeder;
   import instr_feeder_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [IW-1:0] wr_data;
   logic          clear;
   logic          start;
   logic [AW-1:0] address;
   logic [3:0]    opcode;
   logic [7:0]    operand_b;
   logic [7:0]    operand_a;
   logic          op;
   logic          busy;
   logic          done;
   logic          full;
   logic [AW:0]   prog_len;
   logic          seq_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [IW-1:0] model_prog[$];

   instr_feeder dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .clear(clear), .start(start), .address(address),
      .opcode(opcode), .operand_b(operand_b), .operand_a(operand_a),
      .op(op), .busy(busy), .done(done), .full(full),
      .prog_len(prog_len), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required end before 300000ns");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic host_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_prog.delete();
   endtask

   task automatic host_write(input logic [IW-1:0] w, input bit with_start);
      wr_en   = 1'b1;
      wr_data = w;
      if (with_start) begin
         address = '0;
         start   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      if (model_prog.size() < DEPTH) model_prog.push_back(w);
   endtask

   task automatic pulse_start();
      address = '0;
      start   = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_op(output bit ok);
      int budget = 0;
      while (op !== 1'b1 && budget < 20) begin
         tick();
         budget++;
      end
      ok = (op === 1'b1);
   endtask

   // Controller model: accept every issued word in program order, stalling a
   // random number of cycles, acknowledging by bumping the address.
   task automatic run_controller(input int stall_min, input int stall_max);
      bit ok;
      for (int i = 0; i < model_prog.size(); i++) begin
         logic [IW-1:0] w = model_prog[i];
         int stall = $urandom_range(stall_max, stall_min);
         wait_op(ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL op_timeout word %0d: op=%b required 1", i, op);
            return;
         end
         n_checks++;
         if ({opcode, operand_b, operand_a} !== w || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_word %0d: got %h busy=%b required %h busy=1",
                     i, {opcode, operand_b, operand_a}, busy, w);
         end
         for (int s = 0; s < stall; s++) begin
            tick();
            n_checks++;
            if ({op, opcode, operand_b, operand_a} !== {1'b1, w}) begin
               n_fail++;
               $display("FAIL stall_hold word %0d cyc %0d: op=%b instr=%h required op=1 instr=%h",
                        i, s, op, {opcode, operand_b, operand_a}, w);
            end
         end
         address = address + 1'b1;
         tick();
         n_checks++;
         if (i == model_prog.size() - 1) begin
            if ({done, op, busy} !== 3'b100) begin
               n_fail++;
               $display("FAIL done_after_last_ack: done=%b op=%b busy=%b required 1 0 0",
                        done, op, busy);
            end
         end else if ({op, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL fetch_after_ack word %0d: op=%b busy=%b required 0 1", i, op, busy);
         end
      end
      n_checks++;
      if (prog_len !== (AW+1)'(model_prog.size()) || seq_err !== 1'b0) begin
         n_fail++;
         $display("FAIL end_of_run: prog_len=%0d seq_err=%b required %0d 0",
                  prog_len, seq_err, model_prog.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_en = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0; address = '0;
      tick();
      n_checks++;
      if ({op, busy, done, full, seq_err, prog_len, opcode, operand_b, operand_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: op=%b busy=%b done=%b full=%b seq_err=%b len=%0d instr=%h required all 0",
                  op, busy, done, full, seq_err, prog_len, {opcode, operand_b, operand_a});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      host_clear();
      host_write(20'h1_05_03, 1'b0);
      host_write(20'h2_01_02, 1'b0);
      host_write(20'h8_00_04, 1'b0);
      n_checks++;
      if (prog_len !== 5'd3 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_load: prog_len=%0d full=%b required 3 0", prog_len, full);
      end
      pulse_start();
      run_controller(0, 0);
   endtask

   task automatic test_full_wrap();
      host_clear();
      for (int i = 0; i < DEPTH + 1; i++) begin
         host_write(IW'($urandom), 1'b0);
         if (i == DEPTH - 2 || i == DEPTH - 1) begin
            n_checks++;
            if (full !== (i == DEPTH - 1)) begin
               n_fail++;
               $display("FAIL full_flag after %0d writes: full=%b required %b",
                        i + 1, full, (i == DEPTH - 1));
            end
         end
      end
      n_checks++;
      if (prog_len !== 5'd16 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_ignored: prog_len=%0d full=%b required 16 1", prog_len, full);
      end
      pulse_start();
      run_controller(0, 1);
   endtask

   task automatic test_empty();
      host_clear();
      n_checks++;
      if (done !== 1'b0 || prog_len !== '0) begin
         n_fail++;
         $display("FAIL clear_state: done=%b prog_len=%0d required 0 0", done, prog_len);
      end
      pulse_start();
      n_checks++;
      if (done !== 1'b1 || op !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_start: done=%b op=%b required 1 0", done, op);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (op !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_hold cyc %0d: op=%b done=%b required 0 1", i, op, done);
         end
      end
   endtask

   task automatic test_stall();
      host_clear();
      for (int i = 0; i < 3; i++) host_write(IW'($urandom), 1'b0);
      pulse_start();
      run_controller(5, 5);
   endtask

   task automatic test_seq_err();
      bit ok;
      host_clear();
      for (int i = 0; i < 3; i++) host_write(IW'($urandom), 1'b0);
      pulse_start();
      wait_op(ok);
      address = 4'd2;
      tick();
      wait_op(ok);
      n_checks++;
      if (!ok || seq_err !== 1'b1 || {opcode, operand_b, operand_a} !== model_prog[1]) begin
         n_fail++;
         $display("FAIL seq_err_set: op=%b seq_err=%b instr=%h required 1 1 %h",
                  op, seq_err, {opcode, operand_b, operand_a}, model_prog[1]);
      end
      address = 4'd3;
      tick();
      wait_op(ok);
      address = 4'd4;
      tick();
      n_checks++;
      if (done !== 1'b1 || seq_err !== 1'b1) begin
         n_fail++;
         $display("FAIL seq_err_sticky: done=%b seq_err=%b required 1 1", done, seq_err);
      end
      pulse_start();
      n_checks++;
      if (seq_err !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_err_cleared_by_start: seq_err=%b done=%b required 0 0", seq_err, done);
      end
      run_controller(0, 0);
   endtask

   task automatic test_reset_mid_issue();
      bit ok;
      host_clear();
      for (int i = 0; i < 4; i++) host_write(IW'($urandom), 1'b0);
      pulse_start();
      wait_op(ok);
      reset = 1'b1;
      #1;
      n_checks++;
      if (!ok || op !== 1'b0 || busy !== 1'b0 || prog_len !== '0) begin
         n_fail++;
         $display("FAIL async_reset_mid_issue: op=%b busy=%b prog_len=%0d required 0 0 0",
                  op, busy, prog_len);
      end
      tick();
      reset = 1'b0;
      model_prog.delete();
      tick();
      pulse_start();
      n_checks++;
      if (done !== 1'b1 || op !== 1'b0) begin
         n_fail++;
         $display("FAIL start_after_reset: done=%b op=%b required 1 0", done, op);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (op !== 1'b0) begin
            n_fail++;
            $display("FAIL no_op_after_reset cyc %0d: op=%b required 0", i, op);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 5; r++) begin
         int n = $urandom_range(DEPTH, 1);
         bit merge = $urandom_range(1, 0) == 1;
         host_clear();
         for (int i = 0; i < n - 1; i++) host_write(IW'($urandom), 1'b0);
         if (merge) begin
            host_write(IW'($urandom), 1'b1);
         end else begin
            host_write(IW'($urandom), 1'b0);
            pulse_start();
         end
         run_controller(0, 3);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_wrap();
      test_empty();
      test_stall();
      test_seq_err();
      test_reset_mid_issue();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Program store and instruction issuer that sits on the fetch side of the processor controller.
- A host writes 20-bit instruction words sequentially into a 16-entry array.
- On start, the block presents one instruction at a time and raises op, using the controller's address output as the acknowledge.
- Instruction format: [19:16] opcode, [15:8] operand B, [7:0] operand A.

Parameters:
- DEPTH, 16, number of instruction words; must equal 2**AW.
- AW, 4, address width; matches the controller address bus.
- IW, 20, instruction word width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- wr_en  in  1  host write strobe; appends wr_data at wr_ptr
- wr_data  in  IW  instruction word to store
- clear  in  1  empties the program (wr_ptr <= 0) and clears done
- start  in  1  single-cycle pulse; begins issuing from word 0
- address  in  AW  controller program address; a change means the current instruction was accepted
- opcode  out  4  instr_reg[19:16]
- operand_b  out  8  instr_reg[15:8]
- operand_a  out  8  instr_reg[7:0]
- op  out  1  instruction valid; high only in ISSUE
- busy  out  1  high in FETCH or ISSUE
- done  out  1  all prog_len words issued; held until clear or start
- full  out  1  wr_ptr == DEPTH
- prog_len  out  AW+1  current wr_ptr (0..16)
- seq_err  out  1  sticky; controller address mismatched the issue counter

Behaviour:
- Reset (async) forces:
  - state = IDLE; wr_ptr, issue_cnt, issue_addr, instr_reg = 0.
  - op, busy, done, seq_err = 0; full = 0.
  - Array contents are not reset and are retained across reset.
- State machine has four states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr++.
  - wr_en && full: ignored, no state change.
  - clear: wr_ptr <= 0.
  - start with wr_ptr == 0: go to DONE next cycle; op never asserts.
  - start with wr_ptr > 0: issue_cnt <= 0, seq_err <= 0, go to FETCH.
  - Simultaneous start and wr_en: the write takes effect and prog_len includes that word.
  - Simultaneous start and clear: clear wins; treat as an empty program and go to DONE.
- FETCH (exactly 1 cycle):
  - instr_reg <= mem[issue_cnt]; issue_addr <= address.
  - If address != issue_cnt[AW-1:0], set seq_err.
  - Go to ISSUE.
- ISSUE:
  - op = 1 (decoded from state); instr_reg is stable.
  - Hold indefinitely while address == issue_addr (controller stall).
  - When address != issue_addr: issue_cnt++.
  - If issue_cnt+1 == wr_ptr, go to DONE; otherwise go to FETCH.
- DONE:
  - done = 1, op = 0; instr_reg holds the last word.
  - clear: wr_ptr <= 0, done <= 0, go to IDLE.
  - start: restart as from IDLE with the same program; done <= 0.
  - wr_en is ignored.
- In FETCH/ISSUE, wr_en, clear and start are all ignored.
- Timing contract with the controller:
  - Controller accepts at edge t; address changes at t+1.
  - The feeder is in FETCH at t+2 and re-asserts op at t+3, when the controller has returned to its idle state, so there are no wasted cycles.
  - op stays high during the cycle after acceptance; this is harmless because the controller samples op only when idle.
- Width rules:
  - wr_ptr and issue_cnt are AW+1 bits, so full == 16 without aliasing to 0.
  - Address wrap 15->0 on the final word is a valid acknowledge.
- Reset mid-ISSUE: op drops asynchronously; the program remains stored but prog_len reads 0, so the host must reload.

Decomposition:
- Shared package holds:
  - state encodings IDLE/FETCH/ISSUE/DONE;
  - instruction field positions OPC_MSB/LSB, OPB_MSB/LSB, OPA_MSB/LSB;
  - IW/AW/DEPTH defaults, shared with the controller.
- One natural sub-module: prog_ram (DEPTH x IW, synchronous write, read registered into instr_reg by the FSM).

Test Plan:
- Load 0x1_05_03, 0x2_01_02, 0x8_00_04; start; controller model acks each op by incrementing address:
  - op seen 3 times with opcodes 1, 2, 8;
  - operand_a 03, 02, 04;
  - done asserts 1 cycle after the third ack;
  - seq_err = 0.
- Write 17 words:
  - full rises after the 16th;
  - the 17th is ignored and prog_len = 16.
  - Run to completion, including address wrap 15->0: done = 1 after 16 ops.
- Start with an empty program: done = 1 on the next cycle; op stays 0 throughout.
- Controller stalls, holding address for 5 cycles: op stays high with instr_reg unchanged for all 5 cycles, then advances on the address change.
- Address jumps 0->2 on the first ack: seq_err = 1 after the next FETCH and stays sticky; start clears it.
- Reset asserted during ISSUE:
  - op, busy and prog_len go to 0 immediately;
  - start afterwards leads to DONE with no op.
